sram_like_responder: RTL and testbench

Responder (slave) end of the team's SRAM-like req/addr_ok/data_ok interface, the same interface the fetch and memory stages drive as initiators. It accepts address handshakes, performs word-wide reads and byte-masked writes on an internal RAM, and returns responses strictly in order after a programmable latency. An optional pseudo-random stall mode throttles addr_ok and data_ok so that initiators are exercised against non-fixed handshake timing.

---
 rtl/sram_like_responder.sv | 132 +++++++++++++
 tb/tb_sram_like_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface: word RAM with byte-masked
// writes, in-order responses after a programmable latency, optional LFSR-driven stalls.
module sram_like_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LATENCY    = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req,
  input  logic                       wr,
  input  logic [1:0]                 size,
  input  logic [3:0]                 wstrb,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic                       addr_ok,
  output logic                       data_ok,
  output logic [31:0]                rdata,
  input  logic                       rand_en,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  logic [31:0]      mem_q   [WORDS];
  logic [31:0]      qdata_q [DEPTH];
  logic [LAT_W-1:0] qcnt_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] widx_c;
  logic                  astall_c;
  logic                  dstall_c;
  logic                  push_c;
  logic                  pop_c;
  logic [31:0]           rd_word_c;
  logic [31:0]           push_data_c;
  logic                  unused_bits;

  // Byte-lane offset, upper address bits and size carry no information for a word RAM.
  assign widx_c      = addr[ADDR_WIDTH+1:2];
  assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

  assign astall_c = rand_en & lfsr_q[0];
  assign dstall_c = rand_en & lfsr_q[1];

  // Acceptance looks only at the registered occupancy, never at a same-cycle pop.
  assign addr_ok = req & (count_q < FULL) & ~astall_c;
  assign push_c  = req & addr_ok;
  assign pop_c   = (count_q != '0) & (qcnt_q[rd_ptr_q] == '0) & ~dstall_c;

  assign rd_word_c   = mem_q[widx_c];
  assign push_data_c = wr ? 32'd0 : rd_word_c;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    data_ok_d = pop_c;
    rdata_d   = 32'd0;
    lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      rdata_d  = qdata_q[rd_ptr_q];
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lfsr_q    <= lfsr_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // Queue payload and per-entry countdown; stale entries are harmless since count_q gates them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push_c && (wr_ptr_q == PTR_W'(i))) begin
        qdata_q[i] <= push_data_c;
        qcnt_q[i]  <= LAT_LOAD;
      end else if (qcnt_q[i] != '0) begin
        qcnt_q[i] <= qcnt_q[i] - LAT_W'(1);
      end
    end
  end

  // Writes commit at the acceptance edge, so later reads see them regardless of queue state.
  always_ff @(posedge clk) begin
    if (push_c && wr && resetn) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[widx_c][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_ok     = data_ok_q;
  assign rdata       = rdata_q;
  assign outstanding = count_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: two instances (LATENCY 1 and 8) each checked every cycle
// against a timestamped response-queue model, plus hand-computed scenario expectations.
module tb_sram_like_responder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_v, wr_v, ren_v;
  logic [1:0]  size_a  [2];
  logic [3:0]  wstrb_a [2];
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic [1:0]  aok_v, dok_v;
  logic [31:0] rdata_x [2];
  logic [2:0]  outst_x [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d) at %0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 8;

    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [2:0]  outstanding;

    sram_like_responder #(
      .ADDR_WIDTH(12), .DEPTH(DEPTH), .LATENCY(LAT), .LFSR_SEED(16'hACE1)
    ) u_dut (
      .clk(clk), .resetn(resetn), .req(req_v[g]), .wr(wr_v[g]), .size(size_a[g]),
      .wstrb(wstrb_a[g]), .addr(addr_a[g]), .wdata(wdata_a[g]), .addr_ok(addr_ok),
      .data_ok(data_ok), .rdata(rdata), .rand_en(ren_v[g]), .outstanding(outstanding)
    );

    assign aok_v[g]   = addr_ok;
    assign dok_v[g]   = data_ok;
    assign rdata_x[g] = rdata;
    assign outst_x[g] = outstanding;

    // Model: memory as associative array, queue of {data, earliest reply edge}.
    logic [31:0] mem_m [int unsigned];
    logic [31:0] rq_data [$];
    int          rq_ready [$];
    logic [15:0] lfsr_m;
    int          ecyc = 0;
    bit          mvalid = 1'b0;
    bit          exp_dok;
    logic [31:0] exp_rdata;
    bit          m_head, m_pop, m_acc, m_eaok;
    int unsigned m_idx;
    logic [31:0] resp_q [$];
    int          acc_q [$];
    int          dok_q [$];
    int          astall_n = 0;
    int          dstall_n = 0;

    always @(posedge clk) begin
      ecyc++;
      if (!resetn) begin
        rq_data.delete();
        rq_ready.delete();
        lfsr_m    = 16'hACE1;
        exp_dok   = 1'b0;
        exp_rdata = 32'd0;
        mvalid    = 1'b1;
      end else begin
        m_head = (rq_data.size() != 0) && (rq_ready[0] <= ecyc);
        m_pop  = m_head && !(ren_v[g] && lfsr_m[1]);
        if (m_head && !m_pop) dstall_n++;
        m_acc  = req_v[g] && (rq_data.size() < DEPTH) && !(ren_v[g] && lfsr_m[0]);
        exp_dok   = m_pop;
        exp_rdata = m_pop ? rq_data[0] : 32'd0;
        if (m_pop) begin
          void'(rq_data.pop_front());
          void'(rq_ready.pop_front());
        end
        if (m_acc) begin
          m_idx = 32'(addr_a[g][13:2]);
          if (wr_v[g]) begin
            for (int b = 0; b < 4; b++)
              if (wstrb_a[g][b]) mem_m[m_idx][8*b +: 8] = wdata_a[g][8*b +: 8];
            rq_data.push_back(32'd0);
          end else begin
            rq_data.push_back(mem_m[m_idx]);
          end
          rq_ready.push_back(ecyc + LAT);
        end
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      end
    end

    always @(negedge clk) begin
      if (mvalid) begin
        m_eaok = req_v[g] && (rq_data.size() < DEPTH) && !(ren_v[g] && lfsr_m[0]);
        chk("addr_ok", g, 32'(addr_ok), 32'(m_eaok));
        chk("data_ok", g, 32'(data_ok), 32'(exp_dok));
        if (exp_dok) chk("rdata", g, rdata, exp_rdata);
        chk("outstanding", g, 32'(outstanding), 32'(rq_data.size()));
        if (req_v[g] && addr_ok) acc_q.push_back(ecyc + 1);
        if (req_v[g] && !addr_ok && outstanding < 3'(DEPTH)) astall_n++;
        if (data_ok) begin
          resp_q.push_back(rdata);
          dok_q.push_back(ecyc);
        end
      end
    end
  end

  // Present a request and hold it until the handshake edge has passed.
  task automatic issue(input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    int n = 0;
    req_v[k] = 1'b1; wr_v[k] = w; addr_a[k] = a; wdata_a[k] = d; wstrb_a[k] = s;
    size_a[k] = 2'd2;
    while (!got && n < 200) begin
      @(negedge clk);
      got = aok_v[k];
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout (inst %0d) addr %h", k, a);
    end
  endtask

  task automatic idle(input int k, input int n);
    req_v[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b, ab, b2;

  initial begin
    resetn = 1'b0;
    req_v = '0; wr_v = '0; ren_v = '0;
    for (int k = 0; k < 2; k++) begin
      size_a[k] = '0; wstrb_a[k] = '0; addr_a[k] = '0; wdata_a[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_outstanding", k, 32'(outst_x[k]), 32'd0);
      chk("reset_data_ok", k, 32'(dok_v[k]), 32'd0);
      chk("reset_rdata", k, rdata_x[k], 32'd0);
    end

    // Write then read the same word, back to back.
    b = g_inst[0].resp_q.size(); ab = g_inst[0].acc_q.size();
    issue(0, 1'b1, 32'h1C00_0000, 32'hDEAD_BEEF, 4'hF);
    issue(0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0);
    idle(0, 4);
    chk("t1_nresp", 0, 32'(g_inst[0].resp_q.size() - b), 32'd2);
    if (g_inst[0].resp_q.size() >= b + 2) begin
      chk("t1_wr_rdata", 0, g_inst[0].resp_q[b], 32'h0);
      chk("t1_rd_rdata", 0, g_inst[0].resp_q[b+1], 32'hDEAD_BEEF);
      chk("t1_acc_gap", 0, 32'(g_inst[0].acc_q[ab+1] - g_inst[0].acc_q[ab]), 32'd1);
      chk("t1_latency", 0, 32'(g_inst[0].dok_q[b] - g_inst[0].acc_q[ab]), 32'd1);
      chk("t1_dok_gap", 0, 32'(g_inst[0].dok_q[b+1] - g_inst[0].dok_q[b]), 32'd1);
    end
    chk("t1_drained", 0, 32'(outst_x[0]), 32'd0);

    // Single-byte merge.
    b = g_inst[0].resp_q.size();
    issue(0, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF);
    issue(0, 1'b1, 32'h0000_0040, 32'h00AB_0000, 4'h4);
    issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    idle(0, 4);
    chk("t2_nresp", 0, 32'(g_inst[0].resp_q.size() - b), 32'd3);
    if (g_inst[0].resp_q.size() >= b + 3)
      chk("t2_merge", 0, g_inst[0].resp_q[b+2], 32'h11AB_3344);

    // Full queue at LATENCY 8: six held requests, only four accepted before the first reply.
    for (int i = 0; i < 6; i++) issue(1, 1'b1, 32'(i * 4), 32'hA5A5_0000 | 32'(i), 4'hF);
    idle(1, 20);
    b = g_inst[1].resp_q.size(); ab = g_inst[1].acc_q.size();
    for (int i = 0; i < 6; i++) issue(1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle(1, 20);
    chk("t3_nacc", 1, 32'(g_inst[1].acc_q.size() - ab), 32'd6);
    chk("t3_nresp", 1, 32'(g_inst[1].resp_q.size() - b), 32'd6);
    if (g_inst[1].acc_q.size() >= ab + 6 && g_inst[1].resp_q.size() >= b + 6) begin
      chk("t3_acc3", 1, 32'(g_inst[1].acc_q[ab+3] - g_inst[1].acc_q[ab]), 32'd3);
      chk("t3_acc4", 1, 32'(g_inst[1].acc_q[ab+4] - g_inst[1].acc_q[ab]), 32'd9);
      chk("t3_latency", 1, 32'(g_inst[1].dok_q[b] - g_inst[1].acc_q[ab]), 32'd8);
      for (int i = 0; i < 6; i++)
        chk("t3_order", 1, g_inst[1].resp_q[b+i], 32'hA5A5_0000 | 32'(i));
    end

    // Random traffic with stalls enabled, checked cycle by cycle by the model.
    ren_v[0] = 1'b1;
    b = g_inst[0].resp_q.size();
    for (int i = 0; i < 16; i++) issue(0, 1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int n = 0; n < 200; n++) begin
      logic [31:0] r;
      int          word;
      r    = $urandom;
      word = $urandom_range(0, 15);
      issue(0, 1'($urandom_range(0, 1)), (r & 32'hFFFF_C003) | (32'(word) << 2),
            $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(0, 1);
    end
    idle(0, 30);
    ren_v[0] = 1'b0;
    chk("t4_nresp", 0, 32'(g_inst[0].resp_q.size() - b), 32'd216);
    chk("t4_astall_seen", 0, 32'(g_inst[0].astall_n > 0), 32'd1);
    chk("t4_dstall_seen", 0, 32'(g_inst[0].dstall_n > 0), 32'd1);

    // Reset with three requests in flight.
    b = g_inst[1].resp_q.size();
    issue(1, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF);
    issue(1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
    chk("t5_pre_outstanding", 1, 32'(outst_x[1]), 32'd3);
    req_v[1] = 1'b0;
    resetn   = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    chk("t5_outstanding", 1, 32'(outst_x[1]), 32'd0);
    chk("t5_data_ok", 1, 32'(dok_v[1]), 32'd0);
    b2 = g_inst[1].resp_q.size();
    idle(1, 15);
    chk("t5_no_resp", 1, 32'(g_inst[1].resp_q.size() - b), 32'd0);
    issue(1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);
    idle(1, 12);
    chk("t5_nresp", 1, 32'(g_inst[1].resp_q.size() - b2), 32'd1);
    if (g_inst[1].resp_q.size() == b2 + 1)
      chk("t5_persist", 1, g_inst[1].resp_q[b2], 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
